// File: rtl/multi_cycle_mips_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath (shared I/D memory with ready handshake).
// Optional macro MIPS_CTRL_JUMP_EN adds the JUMP state for j; otherwise j decodes as illegal.
module multi_cycle_mips_ctrl #(
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned ALU_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [ALU_W-1:0] alu_ctl,
  output logic [3:0]       state,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRex    = 4'd6,
    StRwb    = 4'd7,
    StIex    = 4'd8,
    StIwb    = 4'd9,
    StBranch = 4'd10,
`ifdef MIPS_CTRL_JUMP_EN
    StJump   = 4'd11,
`endif
    StTrap   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluAnd  = 3'd2;
  localparam logic [2:0] AluOr   = 3'd3;
  localparam logic [2:0] AluXor  = 3'd4;
  localparam logic [2:0] AluNor  = 3'd5;
  localparam logic [2:0] AluSlt  = 3'd6;
  localparam logic [2:0] AluSltu = 3'd7;

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [5:0]  op_q;
  logic [3:0]  funct_q;

  // add..nor occupy 10_0xxx, slt/sltu are 10_101x.
  function automatic logic funct_legal(input logic [5:0] f);
    return (f[5:4] == 2'b10) && (!f[3] || (f[3:1] == 3'b101));
  endfunction

  function automatic logic [2:0] funct_alu(input logic [3:0] f);
    logic [2:0] a;
    a = AluAdd;
    case (f)
      4'b0000, 4'b0001: a = AluAdd;
      4'b0010, 4'b0011: a = AluSub;
      4'b0100:          a = AluAnd;
      4'b0101:          a = AluOr;
      4'b0110:          a = AluXor;
      4'b0111:          a = AluNor;
      4'b1010:          a = AluSlt;
      4'b1011:          a = AluSltu;
      default:          a = AluAdd;
    endcase
    return a;
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return (op[5:3] == 3'b001) && (op[2:0] != 3'b111);
  endfunction

  function automatic logic [2:0] imm_alu(input logic [2:0] op_lo);
    logic [2:0] a;
    a = AluAdd;
    case (op_lo)
      3'b010:  a = AluSlt;
      3'b011:  a = AluSltu;
      3'b100:  a = AluAnd;
      3'b101:  a = AluOr;
      3'b110:  a = AluXor;
      default: a = AluAdd;
    endcase
    return a;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      op_q      <= '0;
      funct_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == StDecode) begin
        op_q    <= opcode;
        funct_q <= funct[3:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    pc_en      = 1'b0;
    pc_source  = 2'd0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_zero   = 1'b0;
    alu_ctl    = ALU_W'(AluAdd);

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        // PC and IR load only on the completing cycle so PC advances once per fetch.
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'd3;
        if (opcode == OpLw || opcode == OpSw)              state_d = StMemAdr;
        else if (opcode == OpRtype && funct_legal(funct)) state_d = StRex;
        else if (opcode == OpBeq || opcode == OpBne)      state_d = StBranch;
        else if (is_imm(opcode))                          state_d = StIex;
`ifdef MIPS_CTRL_JUMP_EN
        else if (opcode == OpJ)                           state_d = StJump;
`endif
        else if (TRAP_ON_ILLEGAL) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          state_d = StFetch;
        end
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (op_q == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StRex: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_W'(funct_alu(funct_q));
        state_d   = StRwb;
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StIex: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_zero  = op_q[2];
        alu_ctl   = ALU_W'(imm_alu(op_q[2:0]));
        state_d   = StIwb;
      end
      StIwb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_W'(AluSub);
        pc_source = 2'd1;
        // op_q[0] separates bne from beq.
        pc_en     = op_q[0] ? ~zero : zero;
        state_d   = StFetch;
      end
`ifdef MIPS_CTRL_JUMP_EN
      StJump: begin
        pc_source = 2'd2;
        pc_en     = 1'b1;
        state_d   = StFetch;
      end
`endif
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase

    if (!reset) begin
      {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
       reg_write, alu_src_a, alu_src_b, ext_zero} = '0;
      alu_ctl = '0;
    end
  end

  assign state      = reset ? state_q : StFetch;
  assign illegal_op = reset & illegal_q;

endmodule

// File: tb/tb_multi_cycle_mips_ctrl.sv
// Directed bench for multi_cycle_mips_ctrl; a second instance covers TRAP_ON_ILLEGAL=0.
module tb_multi_cycle_mips_ctrl;

  localparam int StFetch  = 0;
  localparam int StDecode = 1;
  localparam int StMemAdr = 2;
  localparam int StMemRd  = 3;
  localparam int StMemWb  = 4;
  localparam int StMemWr  = 5;
  localparam int StRex    = 6;
  localparam int StRwb    = 7;
  localparam int StIex    = 8;
  localparam int StIwb    = 9;
  localparam int StBranch = 10;
  localparam int StJump   = 11;
  localparam int StTrap   = 12;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, ext_zero, illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_ctl, state;

  logic       n_pc_en, n_i_or_d, n_mem_read, n_mem_write, n_ir_write, n_reg_dst;
  logic       n_mem_to_reg, n_reg_write, n_alu_src_a, n_ext_zero, n_illegal_op;
  logic [1:0] n_pc_source, n_alu_src_b;
  logic [3:0] n_alu_ctl, n_state;

  logic [17:0] ctl_obs;
  assign ctl_obs = {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero, alu_ctl};

  int total = 0;
  int bad   = 0;

  multi_cycle_mips_ctrl #(.TRAP_ON_ILLEGAL(1'b1), .ALU_W(4)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_ctl(alu_ctl), .state(state),
    .illegal_op(illegal_op)
  );

  multi_cycle_mips_ctrl #(.TRAP_ON_ILLEGAL(1'b0), .ALU_W(4)) u_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(n_pc_en), .pc_source(n_pc_source), .i_or_d(n_i_or_d),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .ext_zero(n_ext_zero),
    .alu_ctl(n_alu_ctl), .state(n_state), .illegal_op(n_illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One cycle: sample on the falling edge, then advance past the next rising edge.
  task automatic at(input string tag, input int st, input int pe, input int ps, input int iod,
                    input int mr, input int mw, input int irw, input int rd, input int m2r,
                    input int rw, input int sa, input int sb, input int ez, input int alu,
                    input int il);
    logic [17:0] exp;
    exp = {1'(pe), 2'(ps), 1'(iod), 1'(mr), 1'(mw), 1'(irw), 1'(rd), 1'(m2r), 1'(rw),
           1'(sa), 2'(sb), 1'(ez), 4'(alu)};
    @(negedge clk);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl_obs), 32'(exp));
    chk({tag, ".illegal"}, 32'(illegal_op), 32'(il));
    nxt();
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    opcode = 6'b000000; funct = 6'b100000;
    nxt(); nxt();
    at("rst", StFetch, 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    reset = 1'b1;

    // add: 4 cycles
    at("add_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("add_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("add_x", StRex,    0,0,0,0,0,0,0,0,0,1,0,0,0,0);
    at("add_w", StRwb,    0,0,0,0,0,0,1,0,1,0,0,0,0,0);

    funct = 6'b101010;  // slt
    at("slt_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("slt_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("slt_x", StRex,    0,0,0,0,0,0,0,0,0,1,0,0,6,0);
    at("slt_w", StRwb,    0,0,0,0,0,0,1,0,1,0,0,0,0,0);

    funct = 6'b100111;  // nor
    at("nor_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("nor_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("nor_x", StRex,    0,0,0,0,0,0,0,0,0,1,0,0,5,0);
    at("nor_w", StRwb,    0,0,0,0,0,0,1,0,1,0,0,0,0,0);

    // lw with 2 fetch waits and 3 memory waits: 10 cycles
    opcode = 6'b100011; mem_ready = 1'b0;
    at("lw_f0", StFetch,  0,0,0,1,0,0,0,0,0,0,1,0,0,0);
    at("lw_f1", StFetch,  0,0,0,1,0,0,0,0,0,0,1,0,0,0);
    mem_ready = 1'b1;
    at("lw_f2", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("lw_d",  StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("lw_a",  StMemAdr, 0,0,0,0,0,0,0,0,0,1,2,0,0,0);
    mem_ready = 1'b0;
    at("lw_r0", StMemRd,  0,0,1,1,0,0,0,0,0,0,0,0,0,0);
    at("lw_r1", StMemRd,  0,0,1,1,0,0,0,0,0,0,0,0,0,0);
    at("lw_r2", StMemRd,  0,0,1,1,0,0,0,0,0,0,0,0,0,0);
    mem_ready = 1'b1;
    at("lw_r3", StMemRd,  0,0,1,1,0,0,0,0,0,0,0,0,0,0);
    at("lw_w",  StMemWb,  0,0,0,0,0,0,0,1,1,0,0,0,0,0);

    // sw; opcode changes after decode, latched copy must steer MEMADR
    opcode = 6'b101011;
    at("sw_f",  StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("sw_d",  StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    opcode = 6'b100011;
    at("sw_a",  StMemAdr, 0,0,0,0,0,0,0,0,0,1,2,0,0,0);
    at("sw_m",  StMemWr,  0,0,1,0,1,0,0,0,0,0,0,0,0,0);

    // bne taken/not taken, beq taken
    opcode = 6'b000101; zero = 1'b1;
    at("bne1_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("bne1_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("bne1_b", StBranch, 0,1,0,0,0,0,0,0,0,1,0,0,1,0);
    zero = 1'b0;
    at("bne0_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("bne0_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("bne0_b", StBranch, 1,1,0,0,0,0,0,0,0,1,0,0,1,0);
    opcode = 6'b000100; zero = 1'b1;
    at("beq1_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("beq1_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("beq1_b", StBranch, 1,1,0,0,0,0,0,0,0,1,0,0,1,0);
    zero = 1'b0;

    opcode = 6'b001101;  // ori
    at("ori_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("ori_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("ori_x", StIex,    0,0,0,0,0,0,0,0,0,1,2,1,3,0);
    at("ori_w", StIwb,    0,0,0,0,0,0,0,0,1,0,0,0,0,0);
    opcode = 6'b001010;  // slti
    at("slti_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("slti_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("slti_x", StIex,    0,0,0,0,0,0,0,0,0,1,2,0,6,0);
    at("slti_w", StIwb,    0,0,0,0,0,0,0,0,1,0,0,0,0,0);

    // reset in the middle of lw discards it
    opcode = 6'b100011;
    at("ab_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("ab_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    reset = 1'b0;
    at("ab_r", StFetch,  0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    reset = 1'b1;
    at("ab_f2", StFetch, 1,0,0,1,0,1,0,0,0,0,1,0,0,0);

    // illegal opcode: TRAP here, NOP in u_nop (both are in DECODE now)
    opcode = 6'b111111;
    #3;
    chk("nop_dec_state", 32'(n_state), 32'(StDecode));
    at("ill_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    #3;
    chk("nop_ret_state", 32'(n_state), 32'(StFetch));
    chk("nop_ret_rw", 32'(n_reg_write), 32'd0);
    chk("nop_ret_ill", 32'(n_illegal_op), 32'd0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'(i);
      zero      = 1'(i >> 1);
      at("trap", StTrap, 0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    end
    mem_ready = 1'b1; zero = 1'b0;
    reset = 1'b0;
    at("trap_rst", StFetch, 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    reset = 1'b1; opcode = 6'b000000; funct = 6'b100010;  // sub
    at("sub_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("sub_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("sub_x", StRex,    0,0,0,0,0,0,0,0,0,1,0,0,1,0);
    at("sub_w", StRwb,    0,0,0,0,0,0,1,0,1,0,0,0,0,0);

    opcode = 6'b000010;  // j
    at("j_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("j_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
`ifdef MIPS_CTRL_JUMP_EN
    at("j_j", StJump,   1,2,0,0,0,0,0,0,0,0,0,0,0,0);
    at("j_f2", StFetch, 1,0,0,1,0,1,0,0,0,0,1,0,0,0);
`else
    at("j_t", StTrap,   0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    at("j_t2", StTrap,  0,0,0,0,0,0,0,0,0,0,0,0,0,1);
`endif

    // R-type with unsupported funct (jr) traps
    reset = 1'b0;
    nxt();
    reset = 1'b1; opcode = 6'b000000; funct = 6'b001000;
    at("jr_f", StFetch,  1,0,0,1,0,1,0,0,0,0,1,0,0,0);
    at("jr_d", StDecode, 0,0,0,0,0,0,0,0,0,0,3,0,0,0);
    at("jr_t", StTrap,   0,0,0,0,0,0,0,0,0,0,0,0,0,1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_mips_ctrl.md
Name: multi_cycle_mips_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath, the successor to the single-cycle core. Sequences fetch/decode/execute/memory/writeback over one shared instruction+data memory with a ready handshake. Emits all datapath mux selects, write enables and ALU function codes. Supports the integer subset the isort program uses.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: unsupported encoding enters TRAP and holds; 0: treated as NOP, return to FETCH
ALU_W, 4, width of alu_ctl

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = in reset)
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory completes access this cycle
pc_en  out  1  PC load enable
pc_source  out  2  0 ALU result, 1 ALUOut, 2 jump target
i_or_d  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_dst  out  1  write reg: 0 rt, 1 rd
mem_to_reg  out  1  writeback: 0 ALUOut, 1 MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 PC, 1 reg A
alu_src_b  out  2  0 reg B, 1 const 4, 2 extended imm, 3 sext imm<<2
ext_zero  out  1  imm extension: 0 sign, 1 zero
alu_ctl  out  ALU_W  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU
state  out  4  current state, debug
illegal_op  out  1  sticky: TRAP entered

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BRANCH, JUMP, TRAP.
- Reset (reset==0 at posedge): state<=FETCH, illegal_op<=0. While reset is low, pc_en, ir_write, mem_read, mem_write and reg_write are forced 0. All other outputs are 0 in reset. Mid-instruction reset aborts and discards the instruction. First fetch occurs in the first cycle with reset==1.
- Outputs are Moore decodes of state plus the opcode/funct latched at DECODE exit. Exception: pc_en in BRANCH depends on zero combinationally.
- FETCH: mem_read=1, i_or_d=0, A=PC, B=4, ADD, pc_source=0.
  - ir_write and pc_en are asserted only in a cycle with mem_ready=1; PC advances exactly once per fetch.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: A=PC, B=3, ADD (branch target into ALUOut). Next state:
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) with legal funct -> REX
  - beq/bne (000100/000101) -> BRANCH
  - addi/addiu/slti/sltiu/andi/ori/xori (001000..001110) -> IEX
  - j (000010) -> JUMP, only with the optional feature enabled
  - anything else -> TRAP (TRAP_ON_ILLEGAL=1) or FETCH (=0, no writes issued)
- MEMADR: A=reg, B=2, sign extend, ADD. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then FETCH. mem_read and mem_write are never both 1.
- REX: A=reg, B=0. funct map:
  - add/addu -> ADD, sub/subu -> SUB, and -> AND, or -> OR, xor -> XOR, nor -> NOR
  - slt (101010) -> SLT, sltu (101011) -> SLTU
  - Next: RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- IEX: A=reg, B=2. addi/addiu -> ADD, slti -> SLT, sltiu -> SLTU, each with ext_zero=0. andi/ori/xori -> AND/OR/XOR with ext_zero=1. Next: IWB. Overflow is never trapped.
- IWB: reg_write=1, reg_dst=0 -> FETCH.
- BRANCH: A=reg, B=0, SUB, pc_source=1. pc_en=zero for beq, ~zero for bne -> FETCH.
- TRAP: all enables 0, illegal_op=1. Exits only via reset.
- Cycle counts with mem_ready tied to 1: lw 5; sw, R-type and imm 4; branch 3. Each memory wait cycle adds 1.

Optional Feature:
MIPS_CTRL_JUMP_EN
- Defined: opcode 000010 goes DECODE -> JUMP. JUMP drives pc_source=2, pc_en=1, then -> FETCH (3 cycles total).
- Undefined: no JUMP state is built; j is handled as an illegal opcode.

Test Plan:
- Hold reset=0 for 3 cycles with mem_ready=1 -> all enables 0, state=FETCH, illegal_op=0. Release -> FETCH asserts mem_read, ir_write, pc_en in the same cycle.
- R-type add (opcode 0, funct 100000), mem_ready=1 -> states FETCH, DECODE, REX (alu_ctl=0), RWB (reg_write=1, reg_dst=1). Return to FETCH after exactly 4 cycles.
- lw (100011) with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMRD -> pc_en and ir_write pulse once. MEMWB asserts reg_write with mem_to_reg=1. Total 10 cycles.
- bne (000101) with zero=1, then again with zero=0 -> pc_en=0 in BRANCH for the first, pc_en=1 with pc_source=1 for the second.
- ori (001101) -> IEX with ext_zero=1, alu_ctl=3, then IWB with reg_dst=0.
- opcode 111111 with TRAP_ON_ILLEGAL=1 -> TRAP, illegal_op=1, held for 20 cycles, cleared by reset. With TRAP_ON_ILLEGAL=0 -> back to FETCH, no reg_write. j (000010) exercised with and without MIPS_CTRL_JUMP_EN.
